// File: rtl/tc_tile_sched_if.sv
// tc_tile_sched_if: tile-issue handshake and partial-sum tag bus between the
// tile scheduler (master) and the tile-select / tc_array / psum-buffer path
// (slave).
//
// Ports (signals):
//   tile_valid  master->slave  tile coordinate valid
//   tile_ready  slave->master  datapath accepts the tile
//   ptr_m/k/n   master->slave  tile origin (row, reduction, column)
//   first_k     master->slave  first reduction slice of this C tile
//   last_k      master->slave  last reduction slice of this C tile
//   psum_valid  master->slave  one tile result is at the array output
//   psum_row    master->slave  row origin of that result
//   psum_col    master->slave  column origin of that result
//   psum_clear  master->slave  overwrite instead of accumulate
//   psum_last   master->slave  the C tile is final after this result
//
// Handshake: a tile transfers in every cycle where tile_valid and tile_ready
// are both high (a "fire"). Once tile_valid is high, ptr_*/first_k/last_k
// stay stable until the fire. tile_valid does not depend on tile_ready.
// The psum_* group has no ready: the slave must take every psum_valid
// cycle, and psum_* are all zero while psum_valid is low.
interface tc_tile_sched_if #(
    parameter int DW_POS = 6
) ();
    logic              tile_valid;
    logic              tile_ready;
    logic [DW_POS-1:0] ptr_m;
    logic [DW_POS-1:0] ptr_k;
    logic [DW_POS-1:0] ptr_n;
    logic              first_k;
    logic              last_k;
    logic              psum_valid;
    logic [DW_POS-1:0] psum_row;
    logic [DW_POS-1:0] psum_col;
    logic              psum_clear;
    logic              psum_last;

    modport master (
        output tile_valid, ptr_m, ptr_k, ptr_n, first_k, last_k,
        output psum_valid, psum_row, psum_col, psum_clear, psum_last,
        input  tile_ready
    );

    modport slave (
        input  tile_valid, ptr_m, ptr_k, ptr_n, first_k, last_k,
        input  psum_valid, psum_row, psum_col, psum_clear, psum_last,
        output tile_ready
    );
endinterface

// File: rtl/tc_tile_sched.sv
// tc_tile_sched: walks the (m,k,n) tile iteration space (m innermost, then
// k, then n), issuing one tile origin per handshake, and delays each issued
// tile's tags through a LAT-deep pipeline so they line up with the array
// output for the partial-sum buffer.
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   start      begin a pass (honoured only in IDLE)
//   abort      terminate the current pass (ISSUE or DRAIN)
//   busy       high in ISSUE and DRAIN
//   done       one-cycle pulse on normal completion
//   dbg_state  current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 DONE)
//   tif        tile handshake and psum tag bus (master side)
module tc_tile_sched #(
    parameter int M      = 32,
    parameter int N      = 32,
    parameter int K      = 32,
    parameter int TILE_M = 4,
    parameter int TILE_N = 4,
    parameter int TILE_K = 8,
    parameter int DW_POS = 6,
    parameter int LAT    = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [1:0]      dbg_state,
    tc_tile_sched_if.master tif
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [DW_POS-1:0] M_LAST = DW_POS'(M - TILE_M);
    localparam logic [DW_POS-1:0] N_LAST = DW_POS'(N - TILE_N);
    localparam logic [DW_POS-1:0] K_LAST = DW_POS'(K - TILE_K);
    localparam logic [DW_POS-1:0] M_STEP = DW_POS'(TILE_M);
    localparam logic [DW_POS-1:0] N_STEP = DW_POS'(TILE_N);
    localparam logic [DW_POS-1:0] K_STEP = DW_POS'(TILE_K);

    state_t            state_q, state_d;
    logic [DW_POS-1:0] m_q, m_d, k_q, k_d, n_q, n_d;

    logic [LAT-1:0]    vld_q;
    logic [LAT-1:0]    clr_q;
    logic [LAT-1:0]    lst_q;
    logic [DW_POS-1:0] row_q [LAT];
    logic [DW_POS-1:0] col_q [LAT];

    logic issue, fire, flush, last_tile, pipe_busy, first_k, last_k;

    assign issue     = (state_q == S_ISSUE);
    assign fire      = issue & tif.tile_ready;
    assign flush     = abort & (issue | (state_q == S_DRAIN));
    assign last_tile = (m_q == M_LAST) && (k_q == K_LAST) && (n_q == N_LAST);
    assign first_k   = issue && (k_q == '0);
    assign last_k    = issue && (k_q == K_LAST);

    // Anything still in flight ahead of the output stage. The output stage
    // itself is excluded so DONE follows the final psum_valid directly.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            pipe_busy = pipe_busy | vld_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            k_q     <= k_d;
            n_q     <= n_d;
        end
    end

    // Pointers are zero whenever no pass is issuing, so IDLE needs no
    // explicit clear beyond the entry paths below.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        k_d     = k_q;
        n_d     = n_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    m_d     = '0;
                    k_d     = '0;
                    n_d     = '0;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    m_d     = '0;
                    k_d     = '0;
                    n_d     = '0;
                end else if (tif.tile_ready) begin
                    if (last_tile) begin
                        state_d = S_DRAIN;
                        m_d     = '0;
                        k_d     = '0;
                        n_d     = '0;
                    end else if (m_q != M_LAST) begin
                        m_d = m_q + M_STEP;
                    end else begin
                        m_d = '0;
                        if (k_q != K_LAST) begin
                            k_d = k_q + K_STEP;
                        end else begin
                            k_d = '0;
                            n_d = n_q + N_STEP;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pipe_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Tag pipeline: shifts every cycle; tags are zeroed on entry for
    // non-fire cycles so psum_* read zero whenever psum_valid is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            clr_q <= '0;
            lst_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
            clr_q <= '0;
            lst_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= fire;
            clr_q[0] <= fire & first_k;
            lst_q[0] <= fire & last_k;
            row_q[0] <= fire ? m_q : '0;
            col_q[0] <= fire ? n_q : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                clr_q[i] <= clr_q[i-1];
                lst_q[i] <= lst_q[i-1];
                row_q[i] <= row_q[i-1];
                col_q[i] <= col_q[i-1];
            end
        end
    end

    assign busy           = issue | (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign dbg_state      = state_q;

    assign tif.tile_valid = issue;
    assign tif.ptr_m      = m_q;
    assign tif.ptr_k      = k_q;
    assign tif.ptr_n      = n_q;
    assign tif.first_k    = first_k;
    assign tif.last_k     = last_k;

    assign tif.psum_valid = vld_q[LAT-1];
    assign tif.psum_clear = clr_q[LAT-1];
    assign tif.psum_last  = lst_q[LAT-1];
    assign tif.psum_row   = row_q[LAT-1];
    assign tif.psum_col   = col_q[LAT-1];
endmodule

// File: tb/tb_tc_tile_sched.sv
module tb_tc_tile_sched;
    localparam int M      = 8;
    localparam int N      = 8;
    localparam int K      = 16;
    localparam int TILE_M = 4;
    localparam int TILE_N = 4;
    localparam int TILE_K = 8;
    localparam int DW_POS = 6;
    localparam int LAT    = 3;

    typedef struct packed {
        logic [DW_POS-1:0] m;
        logic [DW_POS-1:0] k;
        logic [DW_POS-1:0] n;
        logic              fk;
        logic              lk;
    } tile_t;

    typedef struct packed {
        logic [31:0]       due;
        logic [DW_POS-1:0] row;
        logic [DW_POS-1:0] col;
        logic              clr;
        logic              lst;
    } psum_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    tc_tile_sched_if #(.DW_POS(DW_POS)) tif ();

    tc_tile_sched #(
        .M(M), .N(N), .K(K),
        .TILE_M(TILE_M), .TILE_N(TILE_N), .TILE_K(TILE_K),
        .DW_POS(DW_POS), .LAT(LAT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state),
        .tif      (tif)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int    checks   = 0;
    int    failures = 0;
    tile_t tile_q[$];    // tiles the model expects to be issued, in order
    psum_t exp_q[$];     // psum results expected, with their due cycle
    bit    pass_active = 1'b0;
    bit    done_armed  = 1'b0;
    int unsigned done_due = 0;
    int    accepts  = 0;
    int    aborts   = 0;
    int    lost     = 0;
    int    dut_dones = 0;
    int    fire_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model of one pass: n outermost, k, m innermost.
    task automatic model_push_pass();
        tile_t t;
        for (int n = 0; n < N; n += TILE_N)
            for (int k = 0; k < K; k += TILE_K)
                for (int m = 0; m < M; m += TILE_M) begin
                    t.m  = DW_POS'(m);
                    t.k  = DW_POS'(k);
                    t.n  = DW_POS'(n);
                    t.fk = (k == 0);
                    t.lk = (k == K - TILE_K);
                    tile_q.push_back(t);
                end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        tile_t t;
        psum_t e;
        bit    was_active;
        bit    in_done;
        if (!reset_n) begin
            if (pass_active) lost++;
            pass_active = 1'b0;
            done_armed  = 1'b0;
            tile_q.delete();
            exp_q.delete();
        end else begin
            was_active = pass_active;
            in_done    = pass_active && done_armed && (cyc == done_due);

            // psum side
            if (tif.psum_valid) begin
                if (exp_q.size() == 0) begin
                    check("psum_spurious", 32'(tif.psum_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("psum_time", cyc, e.due);
                    check("psum_row", 32'(tif.psum_row), 32'(e.row));
                    check("psum_col", 32'(tif.psum_col), 32'(e.col));
                    check("psum_clear", 32'(tif.psum_clear), 32'(e.clr));
                    check("psum_last", 32'(tif.psum_last), 32'(e.lst));
                end
            end else begin
                check("psum_idle_zero",
                      32'({tif.psum_row, tif.psum_col, tif.psum_clear, tif.psum_last}), 32'd0);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    check("psum_valid_missing", 32'd0, 32'd1);
                end
            end

            // control / handshake side
            check("tile_valid", 32'(tif.tile_valid), 32'(pass_active && tile_q.size() > 0));
            check("busy", 32'(busy), 32'(pass_active && !in_done));
            check("done", 32'(done), 32'(in_done));
            if (done) dut_dones++;

            if (tif.tile_valid && tif.tile_ready) begin
                fire_cnt++;
                if (tile_q.size() == 0) begin
                    check("fire_unexpected", 32'd1, 32'd0);
                end else begin
                    t = tile_q.pop_front();
                    check("ptr_m", 32'(tif.ptr_m), 32'(t.m));
                    check("ptr_k", 32'(tif.ptr_k), 32'(t.k));
                    check("ptr_n", 32'(tif.ptr_n), 32'(t.n));
                    check("first_k", 32'(tif.first_k), 32'(t.fk));
                    check("last_k", 32'(tif.last_k), 32'(t.lk));
                    e.due = cyc + LAT;
                    e.row = t.m;
                    e.col = t.n;
                    e.clr = t.fk;
                    e.lst = t.lk;
                    exp_q.push_back(e);
                    if (tile_q.size() == 0 && pass_active) begin
                        done_armed = 1'b1;
                        done_due   = cyc + LAT + 1;
                    end
                end
            end

            if (abort && pass_active && !in_done) begin
                tile_q.delete();
                exp_q.delete();
                pass_active = 1'b0;
                done_armed  = 1'b0;
                aborts++;
            end

            if (in_done) begin
                pass_active = 1'b0;
                done_armed  = 1'b0;
            end

            if (start && !was_active) begin
                model_push_pass();
                pass_active = 1'b1;
                accepts++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        step();
        start = 1'b0;
        abort = 1'b0;
    endtask

    // mode 0: ready=1; 1: ready pattern 1,0,0; 2: random ready;
    // 3: random ready plus start noise (forced in DONE); 4: abort on 5th fire
    task automatic run_pass(input int mode, input int abort_at, input int budget);
        int i = 0;
        int base = fire_cnt;
        bit aborted = 1'b0;
        while (pass_active && i < budget) begin
            case (mode)
                0, 4:    tif.tile_ready = 1'b1;
                1:       tif.tile_ready = (i % 3 == 0);
                default: tif.tile_ready = ($urandom_range(0, 99) < 60);
            endcase
            abort = 1'b0;
            if (mode == 4 && !aborted && (fire_cnt - base) == 4) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            if (mode == 2 && i == abort_at) abort = 1'b1;
            if (mode == 3)
                start = (done_armed && cyc == done_due) || ($urandom_range(0, 3) == 0 && i < 50);
            step();
            i++;
        end
        start = 1'b0;
        abort = 1'b0;
        check("pass_timeout", 32'(pass_active), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_tile_valid"}, 32'(tif.tile_valid), 32'd0);
        check({tag, "_ptrs"}, 32'({tif.ptr_m, tif.ptr_k, tif.ptr_n}), 32'd0);
        check({tag, "_first_last"}, 32'({tif.first_k, tif.last_k}), 32'd0);
        check({tag, "_psum_valid"}, 32'(tif.psum_valid), 32'd0);
        check({tag, "_psum_tags"},
              32'({tif.psum_row, tif.psum_col, tif.psum_clear, tif.psum_last}), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int dones_before;
        int guard;
        tif.tile_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        // full-rate pass, start together with abort in IDLE
        pulse_start(1'b1);
        run_pass(0, -1, 200);
        step();

        // ready pattern 1,0,0
        pulse_start(1'b0);
        run_pass(1, -1, 200);
        step();

        // abort on the 5th fire, then restart from origin
        dones_before = dut_dones;
        pulse_start(1'b0);
        run_pass(4, -1, 200);
        repeat (LAT + 2) step();
        check("abort_no_done", 32'(dut_dones), 32'(dones_before));
        pulse_start(1'b0);
        run_pass(0, -1, 200);
        step();

        // start noise while busy and in DONE
        pulse_start(1'b0);
        run_pass(3, -1, 600);
        repeat (3) step();

        // random ready with random aborts
        for (int p = 0; p < 8; p++) begin
            pulse_start(1'b0);
            run_pass(2, (p % 2 == 1) ? int'($urandom_range(0, 30)) : -1, 300);
            repeat ($urandom_range(0, 3)) step();
        end

        // abort in IDLE has no effect
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (2) step();

        // asynchronous reset in the middle of DRAIN
        pulse_start(1'b0);
        tif.tile_ready = 1'b1;
        guard = 0;
        while (!(pass_active && tile_q.size() == 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain_reach", 32'(pass_active && tile_q.size() == 0), 32'd1);
        @(negedge clk);
        check("drain_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (12) step();
        check_all_zero("post_rst");

        check("done_count", 32'(dut_dones), 32'(accepts - aborts - lost));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
